// File: rtl/ram_responder_if.sv
// Shared constants plus the dispatcher-to-RAM request/response bundle.
// The dispatcher drives the master side; the RAM target is the slave.
package ram_pkg;
  localparam int EXCEPTION_LEN = 4;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ = 4'd1;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd2;
endpackage

interface ram_if;
  import ram_pkg::*;

  logic [31:0] addr_In;
  logic [31:0] data_In;
  logic [1:0] dataWidth_In;
  logic isRead_In;
  logic select_In;
  logic finish_Out;
  logic [31:0] data_Out;
  logic [EXCEPTION_LEN-1:0] exception_Out;

  modport master (
    output addr_In,
    output data_In,
    output dataWidth_In,
    output isRead_In,
    output select_In,
    input finish_Out,
    input data_Out,
    input exception_Out
  );

  modport slave (
    input addr_In,
    input data_In,
    input dataWidth_In,
    input isRead_In,
    input select_In,
    output finish_Out,
    output data_Out,
    output exception_Out
  );
endinterface

// File: rtl/ram_responder.sv
// Byte-addressable 32-bit-wide synchronous RAM target; sub-word stores
// are read-modify-write, every transaction ends with a GAP cycle.
module ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384
) (
  input logic clk,
  input logic rst,
  ram_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [AW+1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0] width_q, width_d;
  logic rd_q, rd_d;
  logic err_q, err_d;
  logic [31:0] q_q;
  logic [31:0] dout_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic bad_align;
  logic req_err;
  logic [AW-1:0] idx;
  logic [4:0] sh;
  logic [31:0] lane;
  logic [31:0] merged;
  logic [31:0] wdata;
  logic [31:0] done_data;

  assign idx = addr_q[AW+1:2];

  always_comb begin
    bad_align = 1'b1;
    case (bus.dataWidth_In)
      MEM_WIDTH_BYTE: bad_align = 1'b0;
      MEM_WIDTH_HALF: bad_align = bus.addr_In[0];
      MEM_WIDTH_WORD: bad_align = |bus.addr_In[1:0];
      default: bad_align = 1'b1;
    endcase
    req_err = bad_align || ({1'b0, bus.addr_In} >= LIMIT);
  end

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    width_d = width_q;
    rd_d = rd_q;
    err_d = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.select_In) begin
          addr_d = bus.addr_In[AW+1:0];
          data_d = bus.data_In;
          width_d = bus.dataWidth_In;
          rd_d = bus.isRead_In;
          err_d = req_err;
          if (req_err)
            state_d = S_DONE;
          else if (!bus.isRead_In && bus.dataWidth_In == MEM_WIDTH_WORD)
            state_d = S_WRITE;
          else
            state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = rd_q ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE: state_d = S_GAP;
      S_GAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane select for loads and lane merge for sub-word stores.
  always_comb begin
    sh = 5'd0;
    lane = q_q;
    merged = data_q;
    unique case (1'b1)
      width_q == MEM_WIDTH_BYTE: begin
        sh = {addr_q[1:0], 3'b000};
        lane = {24'b0, 8'(q_q >> sh)};
        merged = (q_q & ~(32'hFF << sh))
               | ({24'b0, data_q[7:0]} << sh);
      end
      width_q == MEM_WIDTH_HALF: begin
        sh = {addr_q[1], 4'b0000};
        lane = {16'b0, 16'(q_q >> sh)};
        merged = (q_q & ~(32'hFFFF << sh))
               | ({16'b0, data_q[15:0]} << sh);
      end
      default: begin
        sh = 5'd0;
        lane = q_q;
        merged = data_q;
      end
    endcase
  end

  assign wdata = (width_q == MEM_WIDTH_WORD) ? data_q : merged;
  assign done_data = (rd_q && !err_q) ? lane : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      width_q <= '0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      q_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      width_q <= width_d;
      rd_q <= rd_d;
      err_q <= err_d;
      if (state_q == S_FETCH)
        q_q <= mem_q[idx];
      if (state_q == S_DONE)
        dout_q <= done_data;
    end
  end

  // No reset on the array: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE)
      mem_q[idx] <= wdata;
  end

  assign bus.finish_Out = (state_q == S_DONE);
  assign bus.data_Out = (state_q == S_DONE) ? done_data : dout_q;
  assign bus.exception_Out =
    (state_q == S_DONE && err_q)
      ? (rd_q ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE)
      : EXCEP_OK;

endmodule

// File: tb/tb_ram_responder.sv
// Directed vector bench for ram_responder: table of single transactions
// plus hand sequences for reset and back-to-back behaviour.
module tb_ram_responder;
  import ram_pkg::*;

  localparam int DEPTH = 64;

  logic clk;
  logic rst;
  int tests;
  int fails;

  ram_if bus ();

  ram_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0] width;
    logic rd;
    int exp_cyc;
    logic [31:0] exp_data;
    logic [3:0] exp_exc;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge with the DUT in IDLE.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] w, input logic r,
                         output int cyc, output logic [31:0] dout,
                         output logic [3:0] exc, output logic one_wide);
    bus.addr_In = a;
    bus.data_In = d;
    bus.dataWidth_In = w;
    bus.isRead_In = r;
    bus.select_In = 1'b1;
    cyc = -1;
    dout = 32'hx;
    exc = 4'hx;
    one_wide = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.select_In = 1'b0;
        bus.addr_In = ~a;
        bus.data_In = ~d;
        bus.dataWidth_In = ~w;
        bus.isRead_In = ~r;
      end
      if (bus.finish_Out) begin
        cyc = c;
        dout = bus.data_Out;
        exc = bus.exception_Out;
        break;
      end
    end
    @(negedge clk);
    one_wide = !bus.finish_Out;
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    int cyc;
    logic [31:0] dout;
    logic [3:0] exc;
    logic one;
    run_req(v.addr, v.data, v.width, v.rd, cyc, dout, exc, one);
    chk({v.name, " cycle"}, 32'(cyc), 32'(v.exp_cyc));
    chk({v.name, " data"}, dout, v.exp_data);
    chk({v.name, " exc"}, 32'(exc), 32'(v.exp_exc));
    chk({v.name, " pulse"}, 32'(one), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [31:0] dout;
    logic [3:0] exc;
    logic one;
    logic [3:0] fin;

    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.addr_In = '0;
    bus.data_In = '0;
    bus.dataWidth_In = MEM_WIDTH_WORD;
    bus.isRead_In = 1'b0;
    bus.select_In = 1'b0;

    vecs.push_back('{"init20", 32'h20, 32'h0, MEM_WIDTH_WORD, 1'b0, 2, 32'h0, EXCEP_OK});
    vecs.push_back('{"st_w10", 32'h10, 32'hDEADBEEF, MEM_WIDTH_WORD, 1'b0, 2, 32'h0, EXCEP_OK});
    vecs.push_back('{"ld_w10", 32'h10, 32'h0, MEM_WIDTH_WORD, 1'b1, 2, 32'hDEADBEEF, EXCEP_OK});
    vecs.push_back('{"st_b11", 32'h11, 32'h123456AA, MEM_WIDTH_BYTE, 1'b0, 3, 32'h0, EXCEP_OK});
    vecs.push_back('{"ld_w10b", 32'h10, 32'h0, MEM_WIDTH_WORD, 1'b1, 2, 32'hDEADAAEF, EXCEP_OK});
    vecs.push_back('{"ld_b13", 32'h13, 32'h0, MEM_WIDTH_BYTE, 1'b1, 2, 32'h000000DE, EXCEP_OK});
    vecs.push_back('{"ld_h12", 32'h12, 32'h0, MEM_WIDTH_HALF, 1'b1, 2, 32'h0000DEAD, EXCEP_OK});
    vecs.push_back('{"ld_h11", 32'h11, 32'h0, MEM_WIDTH_HALF, 1'b1, 1, 32'h0, EXCEP_INVALID_MEM_READ});
    vecs.push_back('{"st_w12", 32'h12, 32'h11111111, MEM_WIDTH_WORD, 1'b0, 1, 32'h0, EXCEP_INVALID_MEM_WRITE});
    vecs.push_back('{"ld_w10c", 32'h10, 32'h0, MEM_WIDTH_WORD, 1'b1, 2, 32'hDEADAAEF, EXCEP_OK});
    vecs.push_back('{"ld_oor", 32'(4 * DEPTH), 32'h0, MEM_WIDTH_BYTE, 1'b1, 1, 32'h0, EXCEP_INVALID_MEM_READ});
    vecs.push_back('{"ld_last", 32'(4 * DEPTH - 1), 32'h0, MEM_WIDTH_BYTE, 1'b1, 2, 32'hx, EXCEP_OK});
    vecs.push_back('{"ld_big", 32'hFFFFFFFC, 32'h0, MEM_WIDTH_WORD, 1'b1, 1, 32'h0, EXCEP_INVALID_MEM_READ});
    vecs.push_back('{"st_badw", 32'h10, 32'h0, 2'd3, 1'b0, 1, 32'h0, EXCEP_INVALID_MEM_WRITE});
    vecs.push_back('{"ld_badw", 32'h10, 32'h0, 2'd3, 1'b1, 1, 32'h0, EXCEP_INVALID_MEM_READ});
    vecs.push_back('{"st_w24", 32'h24, 32'h01020304, MEM_WIDTH_WORD, 1'b0, 2, 32'h0, EXCEP_OK});
    vecs.push_back('{"st_h26", 32'h26, 32'h7777BEEF, MEM_WIDTH_HALF, 1'b0, 3, 32'h0, EXCEP_OK});
    vecs.push_back('{"ld_b24", 32'h24, 32'h0, MEM_WIDTH_BYTE, 1'b1, 2, 32'h00000004, EXCEP_OK});
    vecs.push_back('{"st_b27", 32'h27, 32'hFFFFFF5A, MEM_WIDTH_BYTE, 1'b0, 3, 32'h0, EXCEP_OK});
    vecs.push_back('{"ld_h24", 32'h24, 32'h0, MEM_WIDTH_HALF, 1'b1, 2, 32'h00000304, EXCEP_OK});
    vecs.push_back('{"ld_w24", 32'h24, 32'h0, MEM_WIDTH_WORD, 1'b1, 2, 32'h5AEF0304, EXCEP_OK});

    repeat (3) @(negedge clk);
    chk("rst finish", 32'(bus.finish_Out), 32'd0);
    chk("rst data", bus.data_Out, 32'h0);
    chk("rst exc", 32'(bus.exception_Out), 32'(EXCEP_OK));
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].name == "ld_last") begin
        run_req(vecs[i].addr, 32'h0, MEM_WIDTH_BYTE, 1'b1, cyc, dout, exc, one);
        chk("ld_last cycle", 32'(cyc), 32'd2);
        chk("ld_last exc", 32'(exc), 32'(EXCEP_OK));
      end else begin
        apply(vecs[i]);
      end
    end

    // Reset mid-FETCH; data_Out currently holds 0x5AEF0304.
    bus.addr_In = 32'h10;
    bus.dataWidth_In = MEM_WIDTH_WORD;
    bus.isRead_In = 1'b1;
    bus.select_In = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.select_In = 1'b0;
    chk("pre-rst data held", bus.data_Out, 32'h5AEF0304);
    rst = 1'b0;
    #1;
    chk("midfetch finish", 32'(bus.finish_Out), 32'd0);
    chk("midfetch data", bus.data_Out, 32'h0);
    chk("midfetch exc", 32'(bus.exception_Out), 32'(EXCEP_OK));
    @(negedge clk);
    chk("rst hold finish", 32'(bus.finish_Out), 32'd0);
    rst = 1'b1;
    run_req(32'h10, 32'h0, MEM_WIDTH_WORD, 1'b1, cyc, dout, exc, one);
    chk("post-rst cycle", 32'(cyc), 32'd2);
    chk("post-rst data", dout, 32'hDEADAAEF);

    // Back-to-back with select held high.
    bus.addr_In = 32'h10;
    bus.dataWidth_In = MEM_WIDTH_WORD;
    bus.isRead_In = 1'b1;
    bus.select_In = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("b2b finish c%0d", c), 32'(bus.finish_Out),
          32'((c == 2) || (c == 6)));
      if (c == 2 || c == 6)
        chk($sformatf("b2b data c%0d", c), bus.data_Out, 32'hDEADAAEF);
    end
    bus.select_In = 1'b0;
    @(negedge clk);
    chk("b2b idle", 32'(bus.finish_Out), 32'd0);

    // Half store to 0x20 interrupted during WRITE.
    bus.addr_In = 32'h20;
    bus.data_In = 32'h0000BEEF;
    bus.dataWidth_In = MEM_WIDTH_HALF;
    bus.isRead_In = 1'b0;
    bus.select_In = 1'b1;
    @(posedge clk);
    fin = '0;
    @(negedge clk);
    bus.select_In = 1'b0;
    fin[0] = bus.finish_Out;
    @(negedge clk);
    fin[1] = bus.finish_Out;
    rst = 1'b0;
    @(negedge clk);
    fin[2] = bus.finish_Out;
    rst = 1'b1;
    @(negedge clk);
    fin[3] = bus.finish_Out;
    chk("wr-rst no finish", 32'(fin), 32'h0);
    run_req(32'h20, 32'h0, MEM_WIDTH_WORD, 1'b1, cyc, dout, exc, one);
    chk("wr-rst load cycle", 32'(cyc), 32'd2);
    chk("wr-rst load data", dout, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
